// File: rtl/mem_interface_unit.sv
// Byte-wide bridge from the multicycle controller to a handshaked memory; owns IR and MDR.
// Optional MEM_TIMEOUT_EN aborts a WAIT that outlasts TIMEOUT cycles; stall holds the controller meanwhile.
module mem_interface_unit #(
    parameter int WIDTH      = 8,
    parameter int ADDR_WIDTH = 8,
    parameter int TIMEOUT    = 15
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  memread,
    input  logic                  memwrite,
    input  logic                  iord,
    input  logic [3:0]            irwrite,
    input  logic [ADDR_WIDTH-1:0] pc,
    input  logic [ADDR_WIDTH-1:0] aluout,
    input  logic [WIDTH-1:0]      wdata,
    output logic                  mem_req,
    output logic                  mem_we,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [WIDTH-1:0]      mem_wdata,
    input  logic                  mem_ack,
    input  logic [WIDTH-1:0]      mem_rdata,
    output logic                  stall,
    output logic [4*WIDTH-1:0]    instr,
    output logic [WIDTH-1:0]      mdr,
    output logic                  err
);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] WAIT = 2'd1;
    localparam logic [1:0] DONE = 2'd2;

    logic [1:0] state;
    logic [3:0] irw_q;
    logic       access;

`ifdef MEM_TIMEOUT_EN
    localparam int CW = (TIMEOUT < 16) ? 4 : $clog2(TIMEOUT + 1);
    logic [CW-1:0] cnt;
`endif

    assign access  = memread | memwrite;
    assign mem_req = (state == WAIT);

    // Request cycle must stall combinationally so the controller never sees an unstalled strobe.
    always_comb begin
        stall = 1'b0;
        case (state)
            IDLE:    stall = access;
            WAIT:    stall = 1'b1;
            default: stall = 1'b0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            irw_q     <= 4'd0;
            instr     <= '0;
            mdr       <= '0;
            err       <= 1'b0;
`ifdef MEM_TIMEOUT_EN
            cnt       <= '0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (access) begin
                        mem_addr  <= iord ? aluout : pc;
                        mem_we    <= memwrite;
                        mem_wdata <= wdata;
                        irw_q     <= irwrite;
                        if (memread && memwrite)
                            err <= 1'b1;
`ifdef MEM_TIMEOUT_EN
                        cnt   <= '0;
`endif
                        state <= WAIT;
                    end
                end
                WAIT: begin
                    if (mem_ack) begin
                        if (!mem_we) begin
                            if (irw_q == 4'd0)
                                mdr <= mem_rdata;
                            for (int i = 0; i < 4; i++)
                                if (irw_q[i])
                                    instr[i*WIDTH +: WIDTH] <= mem_rdata;
                        end
                        state <= DONE;
                    end
`ifdef MEM_TIMEOUT_EN
                    // cnt holds completed WAIT cycles; this edge would make it TIMEOUT.
                    else if (cnt == CW'(TIMEOUT - 1)) begin
                        err   <= 1'b1;
                        state <= DONE;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
`endif
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_interface_unit.sv
// Bench for mem_interface_unit: directed vector table, corner sequences and randomized accesses vs a lane-level model.
module tb_mem_interface_unit;

    logic       clk = 1'b0;
    logic       rst;
    logic       memread, memwrite, iord;
    logic [3:0] irwrite;
    logic [7:0] pc, aluout, wdata;
    logic       mem_req, mem_we;
    logic [7:0] mem_addr, mem_wdata;
    logic       mem_ack;
    logic [7:0] mem_rdata;
    logic       stall;
    logic [31:0] instr;
    logic [7:0] mdr;
    logic       err;

    mem_interface_unit #(.WIDTH(8), .ADDR_WIDTH(8), .TIMEOUT(15)) dut (
        .clk(clk), .rst(rst), .memread(memread), .memwrite(memwrite), .iord(iord),
        .irwrite(irwrite), .pc(pc), .aluout(aluout), .wdata(wdata),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_ack(mem_ack), .mem_rdata(mem_rdata), .stall(stall),
        .instr(instr), .mdr(mdr), .err(err)
    );

    always #5 clk = ~clk;

    int vectors = 0;
    int miscompares = 0;

    // reference state
    logic [31:0] m_instr;
    logic [7:0]  m_mdr;
    logic        m_err;

    typedef struct {
        bit        mr, mw, io;
        bit [3:0]  irw;
        bit [7:0]  pcv, alu, wd;
        int        dly;
        bit [7:0]  rd;
        bit [31:0] e_instr;
        bit [7:0]  e_mdr;
        bit        e_err;
        int        e_stall;
    } vec_t;

    vec_t tbl[7];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic access(input bit mr, input bit mw, input bit io, input bit [3:0] irw,
                          input bit [7:0] pcv, input bit [7:0] alu, input bit [7:0] wd,
                          input int dly, input bit [7:0] rd, input bit scramble,
                          output int st);
        bit [7:0] e_addr;
        @(negedge clk);
        memread = mr; memwrite = mw; iord = io; irwrite = irw;
        pc = pcv; aluout = alu; wdata = wd;
        e_addr = io ? alu : pcv;
        st = 0;
        #1 if (stall) st++;
        for (int w = 1; w <= dly; w++) begin
            @(negedge clk);
            if (scramble) begin
                memread = 1'($urandom); memwrite = 1'($urandom); iord = 1'($urandom);
                pc = 8'($urandom); aluout = 8'($urandom); wdata = 8'($urandom);
            end
            chk("wait_req", mem_req, 1);
            chk("wait_addr", mem_addr, e_addr);
            chk("wait_we", mem_we, mw);
            chk("wait_wdata", mem_wdata, wd);
            if (stall) st++;
            if (w == dly) begin mem_ack = 1'b1; mem_rdata = rd; end
        end
        @(negedge clk);
        mem_ack = 1'b0; memread = 1'b0; memwrite = 1'b0; irwrite = 4'd0;
        chk("done_stall", stall, 0);
        chk("done_req", mem_req, 0);
        if (mr && mw) m_err = 1'b1;
        if (!mw) begin
            if (irw == 4'd0) m_mdr = rd;
            for (int l = 0; l < 4; l++)
                if (irw[l]) m_instr[l*8 +: 8] = rd;
        end
        chk("instr", instr, m_instr);
        chk("mdr", mdr, m_mdr);
        chk("err", err, m_err);
        chk("stall_cycles", st, 1 + dly);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int st, n;
        bit mr, mw;
        tbl[0] = '{1,0,0,4'b0001,8'h00,8'hF0,8'h00,1,8'h20,32'h00000020,8'h00,0,2};
        tbl[1] = '{1,0,0,4'b0010,8'h01,8'hF0,8'h00,1,8'h11,32'h00001120,8'h00,0,2};
        tbl[2] = '{1,0,0,4'b0100,8'h02,8'hF0,8'h00,1,8'h22,32'h00221120,8'h00,0,2};
        tbl[3] = '{1,0,0,4'b1000,8'h03,8'hF0,8'h00,1,8'h33,32'h33221120,8'h00,0,2};
        tbl[4] = '{1,0,1,4'b0000,8'h04,8'h44,8'h00,5,8'hA5,32'h33221120,8'hA5,0,6};
        tbl[5] = '{0,1,1,4'b0000,8'h04,8'h10,8'h5A,2,8'hEE,32'h33221120,8'hA5,0,3};
        tbl[6] = '{1,0,0,4'b0011,8'h05,8'h00,8'h00,3,8'hC3,32'h3322C3C3,8'hA5,0,4};

        rst = 1'b1; memread = 0; memwrite = 0; iord = 0; irwrite = 0;
        pc = 0; aluout = 0; wdata = 0; mem_ack = 0; mem_rdata = 0;
        m_instr = 0; m_mdr = 0; m_err = 0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_req", mem_req, 0); chk("rst_we", mem_we, 0);
        chk("rst_addr", mem_addr, 0); chk("rst_wdata", mem_wdata, 0);
        chk("rst_stall", stall, 0); chk("rst_instr", instr, 0);
        chk("rst_mdr", mdr, 0); chk("rst_err", err, 0);
        rst = 1'b0;

        for (int i = 0; i < 7; i++) begin
            access(tbl[i].mr, tbl[i].mw, tbl[i].io, tbl[i].irw, tbl[i].pcv, tbl[i].alu,
                   tbl[i].wd, tbl[i].dly, tbl[i].rd, 1'b0, st);
            chk("tbl_instr", instr, tbl[i].e_instr);
            chk("tbl_mdr", mdr, tbl[i].e_mdr);
            chk("tbl_err", err, tbl[i].e_err);
            chk("tbl_stall", st, tbl[i].e_stall);
        end

        // ack while idle must not touch anything
        @(negedge clk); mem_ack = 1'b1; mem_rdata = 8'h99;
        @(negedge clk); mem_ack = 1'b0;
        chk("idle_ack_req", mem_req, 0);
        chk("idle_ack_instr", instr, 32'h3322C3C3);
        chk("idle_ack_mdr", mdr, 8'hA5);

        for (int i = 0; i < 30; i++) begin
            mr = 1'($urandom); mw = 1'($urandom);
            if (!mr && !mw) mr = 1'b1;
            if (mr && mw && ($urandom_range(0, 3) != 0)) mw = 1'b0;
            access(mr, mw, 1'($urandom), 4'($urandom), 8'($urandom), 8'($urandom),
                   8'($urandom), $urandom_range(1, 6), 8'($urandom), 1'b1, st);
        end

        // simultaneous read/write: write wins, err is sticky
        access(1, 1, 1, 4'b0001, 8'h00, 8'h21, 8'h7E, 2, 8'h99, 1'b0, st);
        chk("both_err", err, 1);
        access(1, 0, 1, 4'b0000, 8'h00, 8'h22, 8'h00, 1, 8'h3C, 1'b0, st);
        chk("both_err_sticky", err, 1);

        // reset in the 2nd WAIT cycle, then a late ack
        @(negedge clk); memread = 1; iord = 0; pc = 8'h20; irwrite = 4'b0001;
        @(negedge clk);
        @(negedge clk); rst = 1'b1; memread = 0; irwrite = 0;
        @(negedge clk);
        chk("rstw_req", mem_req, 0); chk("rstw_stall", stall, 0);
        chk("rstw_instr", instr, 0); chk("rstw_err", err, 0);
        rst = 1'b0; mem_ack = 1'b1; mem_rdata = 8'h77;
        @(negedge clk); mem_ack = 1'b0;
        chk("late_ack_instr", instr, 0); chk("late_ack_mdr", mdr, 0);
        chk("late_ack_req", mem_req, 0);
        m_instr = 0; m_mdr = 0; m_err = 0;

        access(1, 0, 1, 4'b0000, 8'h00, 8'h50, 8'h00, 1, 8'h6B, 1'b0, st);

        // no ack at all
        @(negedge clk); memread = 1; iord = 1; aluout = 8'h30; irwrite = 0;
        n = 0;
`ifdef MEM_TIMEOUT_EN
        for (int c = 0; c < 200; c++) begin
            @(negedge clk); memread = 0;
            if (!stall) break;
            n++;
        end
        chk("timeout_wait_cycles", n, 15);
        chk("timeout_err", err, 1);
        chk("timeout_mdr", mdr, m_mdr);
        chk("timeout_instr", instr, m_instr);
`else
        for (int c = 0; c < 120; c++) begin
            @(negedge clk); memread = 0;
            if (stall) n++;
        end
        chk("no_timeout_stall", n, 120);
        chk("no_timeout_err", err, 0);
        chk("no_timeout_mdr", mdr, m_mdr);
        @(negedge clk); rst = 1'b1;
        @(negedge clk); rst = 1'b0;
        chk("recover_stall", stall, 0);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/mem_interface_unit.md
Name: mem_interface_unit

Overview:
- Byte-wide memory bridge between the multicycle controller/datapath and an external handshaked memory.
- Consumes controller strobes: memread, memwrite, iord, irwrite[3:0].
- Owns the 32-bit instruction register (assembled byte-by-byte) and the memory data register (MDR).
- Asserts stall so the controller state and the PC hold while a slow memory access is outstanding.

Parameters:
- WIDTH, 8, data byte width.
- ADDR_WIDTH, 8, address width.
- TIMEOUT, 15, maximum wait cycles for mem_ack before abort (needs TIMEOUT_EN).

Ports:
- clk  in  1  clock
- rst  in  1  reset; synchronous, active-high
- memread  in  1  controller read strobe
- memwrite  in  1  controller write strobe
- iord  in  1  address select: 0 = pc, 1 = aluout
- irwrite  in  4  IR byte-lane enables; bit i loads instr[8i+7:8i]
- pc  in  ADDR_WIDTH  program counter
- aluout  in  ADDR_WIDTH  data address from ALU register
- wdata  in  WIDTH  store data (rt register)
- mem_req  out  1  request to memory
- mem_we  out  1  1 = write, 0 = read; valid while mem_req
- mem_addr  out  ADDR_WIDTH  registered access address
- mem_wdata  out  WIDTH  registered store data
- mem_ack  in  1  memory completion, one-cycle pulse
- mem_rdata  in  WIDTH  read data, valid in the mem_ack cycle
- stall  out  1  hold controller and PC while high
- instr  out  32  instruction register
- mdr  out  WIDTH  memory data register
- err  out  1  sticky access error

Behaviour:
- Reset values: every output 0, state IDLE. instr, mdr, err and the timeout counter are all cleared.
- States are IDLE, WAIT and DONE.
- IDLE:
  - If memread or memwrite is high, capture mem_addr = (iord ? aluout : pc), mem_we = memwrite and mem_wdata = wdata, then go to WAIT.
  - stall is combinational: stall = (memread | memwrite) in IDLE, so the controller does not advance in the request cycle.
- WAIT:
  - mem_req = 1 and stall = 1. Address, we and wdata are held stable.
  - On mem_ack with a read access: load mem_rdata into every instr byte lane whose irwrite bit is set. If no irwrite bit is set, load mdr. Then go to DONE.
  - On mem_ack with a write access: no register update; go to DONE.
- DONE:
  - stall = 0 and mem_req = 0 for exactly one cycle, letting the controller take its transition. Next state is IDLE.
  - A strobe from the controller's new state is sampled in the following IDLE cycle, so back-to-back FETCH1..FETCH4 cost 3 cycles per byte with single-cycle ack.
- Simultaneous memread and memwrite: write has priority, and err is set.
- mem_ack outside WAIT is ignored.
- Strobes that change while in WAIT are ignored; the latched access completes.
- irwrite with multiple bits set: the same byte is written to every selected lane.
- Reset during WAIT: mem_req drops at the next edge. The memory must tolerate an abandoned request.
- instr and mdr hold their value between accesses; only an acknowledged read modifies them.

Optional Feature:
- Macro: MEM_TIMEOUT_EN.
- Defined:
  - A 4-bit+ counter clears on entry to WAIT and increments every WAIT cycle.
  - When the count reaches TIMEOUT without mem_ack: err is set (sticky until rst), instr and mdr are unchanged, and the unit goes to DONE, releasing stall.
- Not defined: no counter; WAIT persists until mem_ack. err is set only by the simultaneous read/write case.

Test Plan:
- Fetch with ack 1 cycle after req, over 4 accesses with irwrite = 0001, 0010, 0100, 1000 and rdata 0x20, 0x11, 0x22, 0x33 -> instr = 0x33221120; stall high 2 cycles per byte; mem_addr = pc each time.
- Load: memread=1, iord=1, aluout=0x44, ack after 5 cycles with rdata 0xA5 -> mem_addr = 0x44, mem_we = 0, stall high 6 cycles, mdr = 0xA5, instr unchanged.
- Store: memwrite=1, iord=1, aluout=0x10, wdata=0x5A -> mem_we = 1, mem_wdata = 0x5A held through WAIT; mdr and instr unchanged; err = 0.
- memread and memwrite both high -> write performed, err = 1 and stays 1 until rst.
- rst asserted in the 2nd WAIT cycle -> mem_req = 0, stall = 0, instr = 0 next cycle; a late mem_ack is ignored.
- MEM_TIMEOUT_EN defined, TIMEOUT = 15, no ack -> stall falls after 15 WAIT cycles, err = 1, mdr unchanged. Not defined -> stall remains high for 100+ cycles.
